bridge_cmd_queue: RTL and testbench
===================================

BRIDGE_CMD_QUEUE -- requirements
Module: bridge_cmd_queue

Interface
REQ-001 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port req_valid  in  1  client request valid.
REQ-004 SHALL have port req_ready  out  1  queue can accept; high iff queue not full.
REQ-005 SHALL have port req_rw  in  1  1=read, 0=write.
REQ-006 SHALL have port req_addr  in  8  DRAM word index, 0..255.
REQ-007 SHALL have port req_wdata  in  64  write data; ignored for reads.
REQ-008 SHALL have port rsp_valid  out  1  response valid, held until accepted.
REQ-009 SHALL have port rsp_ready  in  1  client accepts response.
REQ-010 SHALL have port rsp_rw  out  1  echo of the request's req_rw.
REQ-011 SHALL have port rsp_rdata  out  64  read data; 0 for write responses.
REQ-012 SHALL have ports C_in_valid out 1, C_r_wb out 1, C_addr out 8, C_data_w out 64  command to the AXI bridge.
REQ-013 SHALL have ports C_out_valid in 1, C_data_r in 64  bridge completion and read data.

Function
REQ-014 SHALL buffer requests in a 4-entry in-order FIFO; push on req_valid && req_ready.
REQ-015 SHALL deassert req_ready when 4 entries are held; no push-through when full, even if a pop occurs in the same cycle.
REQ-016 SHALL run FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with one bridge transaction outstanding at most.
REQ-017 IDLE: if FIFO not empty, SHALL go to ISSUE next cycle.
REQ-018 ISSUE: SHALL drive C_in_valid=1 for exactly one cycle with C_r_wb, C_addr, C_data_w taken from the FIFO head, then go to WAIT.
REQ-019 C_r_wb, C_addr, C_data_w SHALL be 0 whenever C_in_valid=0.
REQ-020 WAIT: on C_out_valid=1, SHALL capture C_data_r (reads) or 0 (writes) into rsp_rdata, pop the head, and go to RESP; otherwise stay, with no timeout.
REQ-021 RESP: SHALL hold rsp_valid=1 with rsp_rw and rsp_rdata stable until rsp_ready=1, then go to IDLE.
REQ-022 Minimum turnaround SHALL be: push at cycle t, C_in_valid at t+2, rsp_valid the cycle after C_out_valid.
REQ-023 C_out_valid SHALL be ignored outside WAIT.
REQ-024 Responses SHALL return in exact request order.
REQ-025 Occupancy count SHALL be 3 bits (0..4); read and write pointers SHALL be 2 bits and wrap 3->0.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged.

Reset
REQ-027 On rst=1 at a clock edge, SHALL set FSM=IDLE, count=0, and both pointers=0.
REQ-028 On reset, SHALL set req_ready=1, rsp_valid=0, rsp_rw=0, rsp_rdata=0, C_in_valid=0, C_r_wb=0, C_addr=0, C_data_w=0.
REQ-029 Reset during WAIT SHALL drop the outstanding transaction; the bridge is reset concurrently by the system.

Configuration
REQ-030 Macro BRIDGE_CMD_QUEUE_LAST_WR_HIT_EN SHALL control the last-write hit feature.
REQ-031 With the macro defined, SHALL keep a last-write register (valid bit, 8-bit address, 64-bit data), loaded on each write completion in WAIT and cleared on reset.
REQ-032 With the macro defined, a read at the FIFO head in IDLE whose address matches a valid last-write entry SHALL skip ISSUE and WAIT.
REQ-033 For such a hit, SHALL pop the entry and go directly to RESP next cycle with rsp_rdata = stored data and no bridge command.
REQ-034 Without the macro, the register and hit path SHALL be absent and every request SHALL go through the bridge.

Verification
REQ-035 Reset then single write addr=0x05 data=0x1122334455667788: C_in_valid one cycle with C_r_wb=0, C_addr=0x05; bridge C_out_valid -> rsp_valid, rsp_rw=0, rsp_rdata=0.
REQ-036 Read addr=0xFF, bridge returns 0xDEADBEEFCAFEF00D -> rsp_rdata=0xDEADBEEFCAFEF00D, rsp_rw=1.
REQ-037 Push 5 back-to-back requests with the bridge stalled -> req_ready low after 4th accept; 5th accepted only after the first pop; responses in push order.
REQ-038 Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stable, no new C_in_valid issued.
REQ-039 rst=1 asserted in WAIT -> next cycle all outputs at reset values, req_ready=1, late C_out_valid ignored.
REQ-040 With the macro, write 0x10=0xA5 then read 0x10 -> no second C_in_valid, rsp_rdata=0xA5 one cycle after read reaches IDLE head; without the macro -> bridge read issued.

Source files
------------

// File: rtl/bridge_cmd_queue.sv
// bridge_cmd_queue: 4-deep in-order request FIFO driving a single-outstanding AXI bridge command port.
// Optional last-write hit path is enabled by defining BRIDGE_CMD_QUEUE_LAST_WR_HIT_EN.
//   state | meaning
//   IDLE  | waiting for a queued request at the FIFO head
//   ISSUE | one-cycle C_in_valid pulse carrying the FIFO head
//   WAIT  | bridge transaction outstanding, waiting for C_out_valid
//   RESP  | response held on rsp_* until rsp_ready
module bridge_cmd_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [7:0]  req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_rw,
    output logic [63:0] rsp_rdata,
    output logic        C_in_valid,
    output logic        C_r_wb,
    output logic [7:0]  C_addr,
    output logic [63:0] C_data_w,
    input  logic        C_out_valid,
    input  logic [63:0] C_data_r
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic        fifo_rw   [4];
    logic [7:0]  fifo_addr [4];
    logic [63:0] fifo_data [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        push, pop;
    logic        head_rw;
    logic [7:0]  head_addr;
    logic [63:0] head_data;
    logic        rsp_load;
    logic [63:0] rsp_load_data;
    logic        hit;
    logic [63:0] hit_data;

    // Full blocks pushes outright, even when the head pops in the same cycle.
    assign req_ready = (count != 3'd4);
    assign push      = req_valid && req_ready;
    assign head_rw   = fifo_rw[rd_ptr];
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rw[wr_ptr]   <= req_rw;
            fifo_addr[wr_ptr] <= req_addr;
            fifo_data[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef BRIDGE_CMD_QUEUE_LAST_WR_HIT_EN
    logic        lw_valid;
    logic [7:0]  lw_addr;
    logic [63:0] lw_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            lw_valid <= 1'b0;
            lw_addr  <= 8'd0;
            lw_data  <= 64'd0;
        end else if (state == WAIT && C_out_valid && !head_rw) begin
            lw_valid <= 1'b1;
            lw_addr  <= head_addr;
            lw_data  <= head_data;
        end
    end

    assign hit      = head_rw && lw_valid && (lw_addr == head_addr);
    assign hit_data = lw_data;
`else
    assign hit      = 1'b0;
    assign hit_data = 64'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        rsp_load      = 1'b0;
        rsp_load_data = 64'd0;
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    if (hit) begin
                        pop           = 1'b1;
                        rsp_load      = 1'b1;
                        rsp_load_data = hit_data;
                        state_nxt     = RESP;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (C_out_valid) begin
                    pop           = 1'b1;
                    rsp_load      = 1'b1;
                    rsp_load_data = head_rw ? C_data_r : 64'd0;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rw    <= 1'b0;
            rsp_rdata <= 64'd0;
        end else if (rsp_load) begin
            rsp_rw    <= head_rw;
            rsp_rdata <= rsp_load_data;
        end
    end

    assign rsp_valid  = (state == RESP);
    assign C_in_valid = (state == ISSUE);
    assign C_r_wb     = C_in_valid && head_rw;
    assign C_addr     = C_in_valid ? head_addr : 8'd0;
    assign C_data_w   = C_in_valid ? head_data : 64'd0;

endmodule

// File: tb/tb_bridge_cmd_queue.sv
// Self-checking bench for bridge_cmd_queue: directed vectors, corner sequences and a randomized run
// scored against an in-order request/response model (last-write hits when BRIDGE_CMD_QUEUE_LAST_WR_HIT_EN).
`timescale 1ns/1ps
module tb_bridge_cmd_queue;
`ifdef BRIDGE_CMD_QUEUE_LAST_WR_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [7:0]  req_addr = 8'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_rw;
    logic [63:0] rsp_rdata;
    logic        C_in_valid, C_r_wb, C_out_valid;
    logic [7:0]  C_addr;
    logic [63:0] C_data_w, C_data_r;

    bit          bridge_auto = 1'b0, man_cov = 1'b0;
    logic [63:0] man_cdr = 64'd0;
    bit          auto_cov = 1'b0, auto_real = 1'b0, outstanding = 1'b0;
    logic [63:0] auto_cdr = 64'd0;
    int          lat = 0;
    bit          cmp_real;

    assign C_out_valid = bridge_auto ? auto_cov : man_cov;
    assign C_data_r    = bridge_auto ? auto_cdr : man_cdr;
    assign cmp_real    = bridge_auto ? auto_real : man_cov;

    always #5 clk = ~clk;

    bridge_cmd_queue dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw), .rsp_rdata(rsp_rdata),
        .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r)
    );

    typedef struct packed {
        logic        rw;
        logic [7:0]  addr;
        logic [63:0] data;
    } txn_t;

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [63:0] bdata;
        logic        exp_rw;
        logic [63:0] exp_rdata;
    } vec_t;

    txn_t        push_log[$], cmd_log[$], rsp_log[$];
    logic [63:0] bdata_log[$];
    int          n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Passive observer: records every handshake that the next rising edge will take.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            push_log.delete();
            cmd_log.delete();
            rsp_log.delete();
            bdata_log.delete();
        end else begin
            if (req_valid && req_ready) push_log.push_back({req_rw, req_addr, req_wdata});
            if (C_in_valid)             cmd_log.push_back({C_r_wb, C_addr, C_data_w});
            if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_rw, 8'h00, rsp_rdata});
            if (cmp_real)               bdata_log.push_back(C_data_r);
        end
    end

    // Automatic bridge: random completion latency plus stray C_out_valid pulses when nothing is outstanding.
    always @(negedge clk) begin
        if (!bridge_auto) begin
            auto_cov = 1'b0; auto_real = 1'b0; outstanding = 1'b0; auto_cdr = 64'd0;
        end else if (C_in_valid) begin
            outstanding = 1'b1;
            lat         = $urandom_range(0, 3);
            auto_real   = 1'b0;
            auto_cov    = ($urandom_range(0, 3) == 0);
            auto_cdr    = {$urandom, $urandom};
        end else if (outstanding && lat == 0) begin
            outstanding = 1'b0;
            auto_real   = 1'b1;
            auto_cov    = 1'b1;
            auto_cdr    = {$urandom, $urandom};
        end else begin
            if (outstanding) lat--;
            auto_real = 1'b0;
            auto_cov  = !outstanding && ($urandom_range(0, 3) == 0);
            auto_cdr  = {$urandom, $urandom};
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; bridge_auto = 1'b0; man_cov = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_one(input logic rw, input logic [7:0] a, input logic [63:0] d);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input string tag);
        int g = 0;
        while (rsp_log.size() < n && g < 500) begin
            @(negedge clk);
            g++;
        end
        check({tag, " drained"}, 64'(rsp_log.size() >= n), 64'd1);
    endtask

    // Reference: walk requests in push order; a read hits the last completed write when enabled,
    // otherwise it consumes the next bridge command and the next bridge data word.
    task automatic score(input string tag);
        bit          lw_v = 1'b0;
        logic [7:0]  lw_a = 8'd0;
        logic [63:0] lw_d = 64'd0;
        logic [63:0] exp_d;
        int          ci = 0, bi = 0;
        check({tag, " rsp count"}, 64'(rsp_log.size()), 64'(push_log.size()));
        for (int k = 0; k < push_log.size(); k++) begin
            txn_t r;
            r = push_log[k];
            if (HIT_EN && r.rw && lw_v && lw_a == r.addr) begin
                exp_d = lw_d;
            end else begin
                if (ci < cmd_log.size()) begin
                    check({tag, " cmd rw"}, 64'(cmd_log[ci].rw), 64'(r.rw));
                    check({tag, " cmd addr"}, 64'(cmd_log[ci].addr), 64'(r.addr));
                    if (!r.rw) check({tag, " cmd wdata"}, cmd_log[ci].data, r.data);
                end
                ci++;
                exp_d = r.rw ? ((bi < bdata_log.size()) ? bdata_log[bi] : 64'hx) : 64'd0;
                bi++;
                if (!r.rw) begin lw_v = 1'b1; lw_a = r.addr; lw_d = r.data; end
            end
            if (k < rsp_log.size()) begin
                check({tag, " rsp rw"}, 64'(rsp_log[k].rw), 64'(r.rw));
                check({tag, " rsp rdata"}, rsp_log[k].data, exp_d);
            end
        end
        check({tag, " cmd count"}, 64'(cmd_log.size()), 64'(ci));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, " rsp_rw"}, 64'(rsp_rw), 64'd0);
        check({tag, " rsp_rdata"}, rsp_rdata, 64'd0);
        check({tag, " C_in_valid"}, 64'(C_in_valid), 64'd0);
        check({tag, " C_r_wb"}, 64'(C_r_wb), 64'd0);
        check({tag, " C_addr"}, 64'(C_addr), 64'd0);
        check({tag, " C_data_w"}, C_data_w, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        bit          rdy;
        int          acc, g;
        logic [63:0] exp_d;

        vecs[0] = '{1'b0, 8'h05, 64'h1122334455667788, 64'hAAAA5555AAAA5555, 1'b0, 64'h0};
        vecs[1] = '{1'b1, 8'hFF, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b1, 64'hDEADBEEFCAFEF00D};
        vecs[2] = '{1'b0, 8'h80, 64'h0F0F0F0F0F0F0F0F, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0};
        vecs[3] = '{1'b1, 8'h7F, 64'h0, 64'h0000000000000001, 1'b1, 64'h0000000000000001};
        vecs[4] = '{1'b1, 8'h00, 64'h0, 64'h8000000000000000, 1'b1, 64'h8000000000000000};

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post-reset idle");

        // Single transactions with exact cycle timing
        do_reset();
        for (int i = 0; i < 5; i++) begin
            man_cdr = vecs[i].bdata;
            push_one(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            check("vec t+1 C_in_valid", 64'(C_in_valid), 64'd0);
            @(negedge clk);
            check("vec t+2 C_in_valid", 64'(C_in_valid), 64'd1);
            check("vec C_r_wb", 64'(C_r_wb), 64'(vecs[i].rw));
            check("vec C_addr", 64'(C_addr), 64'(vecs[i].addr));
            if (!vecs[i].rw) check("vec C_data_w", C_data_w, vecs[i].wdata);
            @(negedge clk);
            check("vec wait C_in_valid", 64'(C_in_valid), 64'd0);
            check("vec idle C_addr", 64'(C_addr), 64'd0);
            check("vec idle C_data_w", C_data_w, 64'd0);
            check("vec wait rsp_valid", 64'(rsp_valid), 64'd0);
            man_cov = 1'b1;
            @(negedge clk);
            man_cov = 1'b0;
            check("vec rsp_valid", 64'(rsp_valid), 64'd1);
            check("vec rsp_rw", 64'(rsp_rw), 64'(vecs[i].exp_rw));
            check("vec rsp_rdata", rsp_rdata, vecs[i].exp_rdata);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("vec rsp released", 64'(rsp_valid), 64'd0);
        end

        // Full FIFO with stalled bridge; no push-through on the popping cycle
        do_reset();
        acc = 0; g = 0;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h20; req_wdata = 64'd0;
        while (acc < 4 && g < 20) begin
            rdy = req_ready;
            @(negedge clk);
            g++;
            if (rdy) begin acc++; req_addr = 8'h20 + 8'(acc); end
        end
        check("full accepts back-to-back", 64'(g), 64'd4);
        check("full req_ready low", 64'(req_ready), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("full req_ready held low", 64'(req_ready), 64'd0);
        end
        check("full pushes held at 4", 64'(push_log.size()), 64'd4);
        check("full single cmd", 64'(cmd_log.size()), 64'd1);
        man_cdr = 64'h0123456789ABCDEF;
        man_cov = 1'b1;
        check("full pop cycle req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        man_cov = 1'b0;
        check("full after pop req_ready", 64'(req_ready), 64'd1);
        check("full no push-through", 64'(push_log.size()), 64'd4);
        @(negedge clk);
        req_valid = 1'b0;
        check("full 5th accepted", 64'(push_log.size()), 64'd5);
        rsp_ready = 1'b1;
        bridge_auto = 1'b1;
        wait_rsp(5, "full");
        score("full");

        // Response held under rsp_ready=0 with another request queued
        do_reset();
        bridge_auto = 1'b1;
        push_one(1'b1, 8'h33, 64'd0);
        push_one(1'b0, 8'h34, 64'h5555AAAA5555AAAA);
        g = 0;
        while (!rsp_valid && g < 100) begin @(negedge clk); g++; end
        check("hold rsp_valid reached", 64'(rsp_valid), 64'd1);
        exp_d = (bdata_log.size() > 0) ? bdata_log[0] : 64'hx;
        repeat (10) begin
            @(negedge clk);
            check("hold rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold rsp_rdata", rsp_rdata, exp_d);
            check("hold no new cmd", 64'(cmd_log.size()), 64'd1);
        end
        rsp_ready = 1'b1;
        wait_rsp(2, "hold");
        score("hold");

        // Reset while a bridge write is outstanding, then a late completion
        do_reset();
        push_one(1'b0, 8'h44, 64'hCAFE);
        g = 0;
        while (!C_in_valid && g < 20) begin @(negedge clk); g++; end
        check("rstwait issued", 64'(C_in_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst in wait");
        rst = 1'b0;
        man_cdr = 64'hBAD0BAD0BAD0BAD0;
        man_cov = 1'b1;
        @(negedge clk);
        man_cov = 1'b0;
        repeat (3) begin
            check("late cov rsp_valid", 64'(rsp_valid), 64'd0);
            check("late cov C_in_valid", 64'(C_in_valid), 64'd0);
            check("late cov req_ready", 64'(req_ready), 64'd1);
            @(negedge clk);
        end

        // Write 0x10 then read 0x10: hit path (when built in) answers without the bridge
        do_reset();
        bridge_auto = 1'b1;
        rsp_ready = 1'b1;
        push_one(1'b0, 8'h10, 64'hA5);
        wait_rsp(1, "lastwr write");
        push_one(1'b1, 8'h10, 64'd0);
        @(negedge clk);
        check("lastwr t+2 rsp_valid", 64'(rsp_valid), 64'(HIT_EN));
        check("lastwr t+2 C_in_valid", 64'(C_in_valid), 64'(!HIT_EN));
        wait_rsp(2, "lastwr read");
        check("lastwr cmd count", 64'(cmd_log.size()), HIT_EN ? 64'd1 : 64'd2);
        score("lastwr");

        // Randomized traffic against the in-order model
        do_reset();
        bridge_auto = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req_valid = $urandom_range(0, 1);
            req_rw    = $urandom_range(0, 1);
            req_addr  = 8'($urandom_range(0, 7));
            req_wdata = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        wait_rsp(push_log.size(), "random");
        check("random traffic seen", 64'(push_log.size() > 100), 64'd1);
        score("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
